// File: rtl/display_arb_pkg.sv
// Shared constants, state encoding and helpers for the display bus arbiter.
// The priority rotation option is controlled by the ARB_ROUND_ROBIN_EN macro in display_bus_arbiter.
package display_arb_pkg;

  localparam int NREQ            = 8;
  localparam int IDW             = 3;
  localparam int TIMEOUT_DEFAULT = 255;

  // Encoding 2'd3 is unused; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational priority picker: i_top has highest priority, then i_top-1, ... wrapping mod NREQ.
module arb_priority_pick
  import display_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_top,
  output logic [IDW-1:0]  o_winner,
  output logic            o_any
);

  logic [IDW-1:0]  w_idx [NREQ];
  logic [NREQ-1:0] w_hit;

  // Rank gi holds the requester index that is gi steps below the top pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rank
      assign w_idx[gi] = i_top - IDW'(gi);
      assign w_hit[gi] = i_req[w_idx[gi]];
    end
  endgenerate

  always_comb begin
    o_any    = |w_hit;
    o_winner = i_top;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_hit[i]) o_winner = w_idx[i];
    end
  end

endmodule

// File: rtl/display_bus_arbiter.sv
// Arbitrates one display-memory read port among NREQ requesters with hold timeout and a recovery cycle.
// Define ARB_ROUND_ROBIN_EN to rotate priority after every tenure; otherwise fixed priority (7 highest).
module display_bus_arbiter
  import display_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TOW     = 8
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid,
  output logic            timeout_flag
);

  arb_state_t      r_state, w_state_next;
  logic [NREQ-1:0] r_grant, w_grant_next;
  logic [IDW-1:0]  r_grant_id, w_grant_id_next;
  logic            r_grant_valid;
  logic            r_timeout, w_timeout_next;
  logic [TOW-1:0]  r_hold, w_hold_next;

  logic [IDW-1:0]  w_top;
  logic [IDW-1:0]  w_winner;
  logic            w_any;
  logic            w_owner_req;
  logic            w_expired;
  logic            w_exit;

  assign w_owner_req = req[r_grant_id];
  assign w_expired   = (r_hold == TOW'(TIMEOUT));
  assign w_exit      = done | ~w_owner_req | w_expired;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] r_ptr;

  // After owner k finishes, k-1 becomes top priority and k drops to the bottom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (r_state == OWN && w_exit) begin
      r_ptr <= r_grant_id - IDW'(1);
    end
  end

  assign w_top = r_ptr;
`else
  assign w_top = IDW'(NREQ - 1);
`endif

  arb_priority_pick u_pick (
    .i_req    (req),
    .i_top    (w_top),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_grant_id_next = r_grant_id;
    w_hold_next     = r_hold;
    w_timeout_next  = 1'b0;
    case (r_state)
      OWN: begin
        if (w_exit) begin
          w_state_next   = RECOVER;
          w_grant_next   = '0;
          w_hold_next    = '0;
          // Timeout only counts when neither done nor a dropped request also ended the tenure.
          w_timeout_next = w_expired & ~done & w_owner_req;
        end else if (r_hold != '1) begin
          w_hold_next = r_hold + TOW'(1);
        end
      end
      RECOVER: begin
        w_state_next = IDLE;
        w_grant_next = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = '0;
        if (w_any) begin
          w_state_next    = OWN;
          w_grant_next    = idx_to_onehot(w_winner);
          w_grant_id_next = w_winner;
          w_hold_next     = TOW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_grant_id    <= w_grant_id_next;
      r_grant_valid <= |w_grant_next;
      r_timeout     <= w_timeout_next;
      r_hold        <= w_hold_next;
    end
  end

  assign grant        = r_grant;
  assign grant_id     = r_grant_id;
  assign grant_valid  = r_grant_valid;
  assign timeout_flag = r_timeout;

endmodule
